// File: rtl/endeavour_pkg.sv
// Shared types and defaults for the Endeavour CMD-line transmitter.
// Holds the phase enum, default pulse widths and timer sizing helpers.
package endeavour_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP,
        ST_WORDGAP
    } state_e;

    localparam int TICKS_DIT_D     = 14;
    localparam int TICKS_DAH_D     = 76;
    localparam int TICKS_BITGAP_D  = 11;
    localparam int TICKS_WORDGAP_D = 100;

    function automatic int max_ticks(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int timer_w(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/endeavour_tx_serializer_if.sv
// Command request channel from the register stage to the serializer.
// Valid/ready handshake carrying a right-aligned word and its bit count.
interface endeavour_tx_serializer_if #(
    parameter int MAX_BITS = 64
);
    localparam int NB_W = $clog2(MAX_BITS + 1);

    logic                valid;
    logic                ready;
    logic [MAX_BITS-1:0] data;
    logic [NB_W-1:0]     nbits;

    modport master (
        output valid,
        output data,
        output nbits,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  nbits,
        output ready
    );
endinterface

// File: rtl/endeavour_tick_timer.sv
// Loadable down-counter shared by every keying phase.
// expire is high while the count sits at zero.
module endeavour_tick_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/endeavour_tx_serializer.sv
// Pulse-width keys one Endeavour command word onto the CMD line.
// Long high = '1', short high = '0', MSB of the word goes first.
module endeavour_tx_serializer
    import endeavour_pkg::*;
#(
    parameter int MAX_BITS      = 64,
    parameter int TICKS_DIT     = TICKS_DIT_D,
    parameter int TICKS_DAH     = TICKS_DAH_D,
    parameter int TICKS_BITGAP  = TICKS_BITGAP_D,
    parameter int TICKS_WORDGAP = TICKS_WORDGAP_D
) (
    input  logic ACLK,
    input  logic ARESET,
    endeavour_tx_serializer_if.slave s,
    output logic cmd_out,
    output logic busy,
    output logic done,
    output logic err_nbits
);

    localparam int NB_W  = $clog2(MAX_BITS + 1);
    localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int TW    = timer_w(max_ticks(
        TICKS_DIT, TICKS_DAH, TICKS_BITGAP, TICKS_WORDGAP));

    localparam logic [TW-1:0] LV_DIT = TW'(TICKS_DIT - 1);
    localparam logic [TW-1:0] LV_DAH = TW'(TICKS_DAH - 1);
    localparam logic [TW-1:0] LV_BG  = TW'(TICKS_BITGAP - 1);
    localparam logic [TW-1:0] LV_WG  = TW'(TICKS_WORDGAP - 1);
    localparam logic [NB_W-1:0] NB_MAX = NB_W'(MAX_BITS);

    if (TICKS_DIT < 1 || TICKS_DAH < 1 ||
        TICKS_BITGAP < 1 || TICKS_WORDGAP < 1) begin : g_bad_ticks
        $error("all TICKS_* parameters must be >= 1");
    end

    state_e              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [MAX_BITS-1:0] data_q, data_n;
    logic                load;
    logic [TW-1:0]       load_val;
    logic                expire;
    logic                done_n, err_n;
    logic                illegal;
    logic [IDX_W-1:0]    first_idx;

    assign illegal   = (s.nbits == '0) || (s.nbits > NB_MAX);
    assign first_idx = IDX_W'(s.nbits - NB_W'(1));
    assign s.ready   = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    endeavour_tick_timer #(
        .W(TW)
    ) u_timer (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        data_n   = data_q;
        load     = 1'b0;
        load_val = '0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s.valid && illegal) begin
                    err_n = 1'b1;
                end else if (s.valid) begin
                    state_n  = ST_HIGH;
                    data_n   = s.data;
                    idx_n    = first_idx;
                    load     = 1'b1;
                    load_val = s.data[first_idx] ? LV_DAH : LV_DIT;
                end
            end
            ST_HIGH: begin
                if (expire && idx == '0) begin
                    state_n  = ST_WORDGAP;
                    load     = 1'b1;
                    load_val = LV_WG;
                end else if (expire) begin
                    state_n  = ST_GAP;
                    idx_n    = idx - IDX_W'(1);
                    load     = 1'b1;
                    load_val = LV_BG;
                end
            end
            ST_GAP: begin
                if (expire) begin
                    state_n  = ST_HIGH;
                    load     = 1'b1;
                    load_val = data_q[idx] ? LV_DAH : LV_DIT;
                end
            end
            ST_WORDGAP: begin
                if (expire) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // cmd_out comes straight from a flop so the line never glitches.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            idx       <= '0;
            data_q    <= '0;
            cmd_out   <= 1'b0;
            done      <= 1'b0;
            err_nbits <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            data_q    <= data_n;
            cmd_out   <= (state_n == ST_HIGH);
            done      <= done_n;
            err_nbits <= err_n;
        end
    end

endmodule

// File: tb/tb_endeavour_tx_serializer.sv
// Self-checking bench for endeavour_tx_serializer.
// Vectors, hand sequences and random words against a waveform model.
module tb_endeavour_tx_serializer;

    logic ACLK = 1'b0;
    logic ARESET;
    logic cmd_out, busy, done, err_nbits;
    int   checks = 0;
    int   failures = 0;

    always #5 ACLK = ~ACLK;

    endeavour_tx_serializer_if #(.MAX_BITS(64)) s_if ();

    endeavour_tx_serializer #(.MAX_BITS(64)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s         (s_if),
        .cmd_out   (cmd_out),
        .busy      (busy),
        .done      (done),
        .err_nbits (err_nbits)
    );

    typedef struct {
        logic [63:0] data;
        int          nbits;
        int          exp_len;
        string       name;
    } vec_t;

    vec_t tbl [7];
    bit   exp_q [$];

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference waveform: one entry per cycle after the accept edge.
    function automatic void build_model(input logic [63:0] d,
                                        input int nb);
        exp_q.delete();
        for (int i = nb - 1; i >= 0; i--) begin
            repeat (d[i] ? 76 : 14) exp_q.push_back(1'b1);
            if (i > 0) repeat (11) exp_q.push_back(1'b0);
        end
        repeat (100) exp_q.push_back(1'b0);
    endfunction

    task automatic send(input logic [63:0] d, input int nb,
                        input int exp_len, input string nm);
        int errs;
        int done_at;
        int len;
        bit ill;
        ill = (nb == 0) || (nb > 64);
        @(negedge ACLK);
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.nbits = 7'(nb);
        @(posedge ACLK);
        @(negedge ACLK);
        s_if.valid = 1'b0;
        s_if.data  = {$urandom, $urandom};
        s_if.nbits = 7'($urandom);
        if (ill) begin
            chk({nm, " err"}, err_nbits, 1);
            chk({nm, " ready"}, s_if.ready, 1);
            errs = 0;
            for (int j = 0; j < 20; j++) begin
                @(negedge ACLK);
                if (cmd_out || busy || done || err_nbits || !s_if.ready)
                    errs++;
            end
            chk({nm, " quiet"}, errs, 0);
            return;
        end
        build_model(d, nb);
        len = (exp_len < 0) ? exp_q.size() : exp_len;
        errs = 0;
        done_at = -1;
        for (int j = 0; j < exp_q.size() + 10; j++) begin
            if (j > 0) @(negedge ACLK);
            if (done) begin
                done_at = j;
                break;
            end
            if (j < exp_q.size() &&
                (cmd_out !== exp_q[j] || busy !== 1'b1 ||
                 err_nbits !== 1'b0))
                errs++;
        end
        chk({nm, " wave"}, errs, 0);
        chk({nm, " done_at"}, done_at, len);
        chk({nm, " ready@done"}, s_if.ready, 1);
        chk({nm, " busy@done"}, busy, 0);
        @(negedge ACLK);
        chk({nm, " done_pulse"}, done, 0);
    endtask

    initial begin
        int errs;
        int done_at;
        int nb;

        tbl[0] = '{64'b101, 3, 288, "w3_101"};
        tbl[1] = '{64'h0, 0, 0, "nb0"};
        tbl[2] = '{64'h5, 65, 0, "nb65"};
        tbl[3] = '{64'h0, 1, 114, "w1_0"};
        tbl[4] = '{64'h1, 1, 176, "w1_1"};
        tbl[5] = '{64'h2, 2, 201, "w2_10"};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 5657, "w64_ones"};

        ARESET     = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.nbits = '0;
        repeat (3) @(negedge ACLK);
        chk("rst cmd_out", cmd_out, 0);
        chk("rst ready", s_if.ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err_nbits, 0);
        ARESET = 1'b0;

        errs = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge ACLK);
            if (cmd_out || busy || done || err_nbits || !s_if.ready)
                errs++;
        end
        chk("idle50", errs, 0);

        for (int i = 0; i < 7; i++)
            send(tbl[i].data, tbl[i].nbits, tbl[i].exp_len, tbl[i].name);

        // s_valid held across a 1-bit word: re-accept only in done cycle.
        @(negedge ACLK);
        s_if.valid = 1'b1;
        s_if.data  = '0;
        s_if.nbits = 7'd1;
        @(posedge ACLK);
        errs = 0;
        done_at = -1;
        for (int j = 0; j < 130; j++) begin
            @(negedge ACLK);
            if (done) begin
                done_at = j;
                break;
            end
            if (cmd_out !== (j < 14) || !busy) errs++;
        end
        chk("hold wave", errs, 0);
        chk("hold done_at", done_at, 114);
        chk("hold ready@done", s_if.ready, 1);
        @(negedge ACLK);
        s_if.valid = 1'b0;
        chk("hold 2nd high", cmd_out, 1);
        chk("hold 2nd busy", busy, 1);
        done_at = -1;
        for (int k = 1; k < 130; k++) begin
            @(negedge ACLK);
            if (done) begin
                done_at = k;
                break;
            end
        end
        chk("hold 2nd done_at", done_at, 114);

        // Abort an 8-bit word in the middle of its first DAH pulse.
        @(negedge ACLK);
        s_if.valid = 1'b1;
        s_if.data  = 64'hA5;
        s_if.nbits = 7'd8;
        @(posedge ACLK);
        @(negedge ACLK);
        s_if.valid = 1'b0;
        repeat (29) @(negedge ACLK);
        chk("abort pre cmd_out", cmd_out, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("abort cmd_out", cmd_out, 0);
        chk("abort ready", s_if.ready, 1);
        chk("abort busy", busy, 0);
        ARESET = 1'b0;
        errs = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge ACLK);
            if (done || cmd_out || busy || err_nbits) errs++;
        end
        chk("abort quiet", errs, 0);
        send(64'h2, 2, 201, "post_abort");

        for (int r = 0; r < 12; r++) begin
            nb = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) nb = $urandom_range(65, 127);
            send({$urandom, $urandom}, nb, -1, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
